// File: rtl/rx_xfer_sequencer.sv
// Sequences the 8-to-N RX width converter for one I3C private write: forwards and
// counts bytes, flushes a trailing partial word, waits for the drain, then emits a length descriptor.
module rx_xfer_sequencer #(
  parameter int Width    = 32,
  parameter int MaxBytes = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_byte_valid_i,
  output logic        rx_byte_ready_o,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_end_valid_i,
  output logic        rx_end_ready_o,
  output logic        conv_valid_o,
  input  logic        conv_ready_i,
  output logic [7:0]  conv_data_o,
  output logic        conv_flush_o,
  input  logic        conv_word_valid_i,
  input  logic        conv_word_ready_i,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic [31:0] desc_data_o
);
  localparam int Bytes = Width / 8;
  localparam int CntW  = $clog2(MaxBytes + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxBytes);
  localparam logic [CntW-1:0] SeenMax = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_FLUSH,
    ST_DRAIN,
    ST_DESC
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [CntW-1:0] r_wexp, w_wexp_nxt;
  logic [CntW-1:0] r_wseen, w_wseen_inc, w_wseen_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_flush;
  logic            r_desc_valid;
  logic [31:0]     r_desc_data;

  logic w_open, w_full, w_fwd, w_drop, w_end, w_partial, w_word_hs, w_desc_hs;

  // Receiver handshakes pass straight through while a transfer is open.
  always_comb begin
    w_open          = (r_state == ST_IDLE) || (r_state == ST_XFER);
    w_full          = (r_cnt == CntMax);
    conv_data_o     = rx_byte_i;
    conv_valid_o    = w_open && !w_full && rx_byte_valid_i;
    rx_byte_ready_o = w_open && (w_full || conv_ready_i);
    rx_end_ready_o  = w_open;
    w_fwd           = conv_valid_o && conv_ready_i;
    w_drop          = w_open && w_full && rx_byte_valid_i;
    w_end           = w_open && rx_end_valid_i;
    w_word_hs       = conv_word_valid_i && conv_word_ready_i;
    w_desc_hs       = r_desc_valid && desc_ready_i;
    w_wseen_inc     = (w_word_hs && (r_wseen != SeenMax)) ? r_wseen + CntW'(1) : r_wseen;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CntW'(w_fwd);
    w_wexp_nxt  = r_wexp;
    w_wseen_nxt = w_wseen_inc;
    w_ovf_nxt   = r_ovf | w_drop;
    // A byte accepted alongside the end is already part of w_cnt_nxt.
    w_partial   = (32'(w_cnt_nxt) % 32'(Bytes)) != 32'd0;
    case (r_state)
      ST_IDLE, ST_XFER: begin
        if (w_fwd) begin
          w_state_nxt = ST_XFER;
        end
        if (w_end && (w_cnt_nxt != '0)) begin
          w_wexp_nxt  = CntW'(32'(w_cnt_nxt) / 32'(Bytes)) + CntW'(w_partial);
          w_state_nxt = w_partial ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_FLUSH: w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_wseen_inc >= r_wexp) begin
          w_state_nxt = ST_DESC;
        end
      end
      ST_DESC: begin
        if (w_desc_hs) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_wexp_nxt  = '0;
          w_wseen_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wexp       <= '0;
      r_wseen      <= '0;
      r_ovf        <= 1'b0;
      r_flush      <= 1'b0;
      r_desc_valid <= 1'b0;
      r_desc_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wexp       <= w_wexp_nxt;
      r_wseen      <= w_wseen_nxt;
      r_ovf        <= w_ovf_nxt;
      r_flush      <= (w_state_nxt == ST_FLUSH);
      r_desc_valid <= (w_state_nxt == ST_DESC);
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DESC)) begin
        r_desc_data <= 32'(r_cnt) | {r_ovf, 31'd0};
      end else if (w_desc_hs) begin
        r_desc_data <= '0;
      end
    end
  end

  assign conv_flush_o = r_flush;
  assign desc_valid_o = r_desc_valid;
  assign desc_data_o  = r_desc_data;

endmodule

// File: tb/tb_rx_xfer_sequencer.sv
// Bench for rx_xfer_sequencer: behavioural converter plus transfer-level reference of
// expected words and descriptors, directed cases followed by randomized transfers.
module tb_rx_xfer_sequencer;
  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_byte_valid_i, rx_byte_ready_o;
  logic [7:0]  rx_byte_i;
  logic        rx_end_valid_i, rx_end_ready_o;
  logic        conv_valid_o, conv_ready_i;
  logic [7:0]  conv_data_o;
  logic        conv_flush_o;
  logic        conv_word_valid_i, conv_word_ready_i;
  logic        desc_valid_o, desc_ready_i;
  logic [31:0] desc_data_o;

  always #5 clk = ~clk;

  rx_xfer_sequencer #(.Width(32), .MaxBytes(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_byte_valid_i(rx_byte_valid_i), .rx_byte_ready_o(rx_byte_ready_o), .rx_byte_i(rx_byte_i),
    .rx_end_valid_i(rx_end_valid_i), .rx_end_ready_o(rx_end_ready_o),
    .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i), .conv_data_o(conv_data_o),
    .conv_flush_o(conv_flush_o),
    .conv_word_valid_i(conv_word_valid_i), .conv_word_ready_i(conv_word_ready_i),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_data_o(desc_data_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  part_q[$];
  logic [31:0] word_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_desc_q[$];
  logic [7:0]  tx_q[$];

  // ready modes: 0 held low, 1 random, 2 held high
  int word_rdy_mode, desc_rdy_mode, conv_rdy_mode;
  logic        prev_dv, prev_dr, prev_flush;
  logic [31:0] prev_dd;
  logic        last_byte_hs, last_end_hs;
  logic [31:0] last_desc, last_word;
  int flush_cnt, fwd_cnt, byte_cnt, desc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  function automatic logic pick(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 99) < 70);
    return 1'b0;
  endfunction

  // One clock: check outputs at the falling edge, then advance the converter model.
  task automatic cycle();
    logic fwd, flush_s, wd_hs, dv, dr, bhs, ehs;
    logic [7:0]  data;
    logic [31:0] dd, w;
    @(negedge clk);
    fwd     = conv_valid_o & conv_ready_i;
    data    = conv_data_o;
    flush_s = conv_flush_o;
    wd_hs   = conv_word_valid_i & conv_word_ready_i;
    dv      = desc_valid_o;
    dr      = desc_ready_i;
    dd      = desc_data_o;
    bhs     = rx_byte_valid_i & rx_byte_ready_o;
    ehs     = rx_end_valid_i & rx_end_ready_o;
    if (flush_s) begin
      chk("flush_excl_valid", conv_valid_o, 0);
      chk("flush_byte_rdy", rx_byte_ready_o, 0);
      chk("flush_end_rdy", rx_end_ready_o, 0);
    end
    if (prev_flush) chk("flush_one_cycle", flush_s, 0);
    if (dv) begin
      chk("desc_byte_rdy", rx_byte_ready_o, 0);
      chk("desc_end_rdy", rx_end_ready_o, 0);
    end
    if (prev_dv && !prev_dr) begin
      chk("desc_held", dv, 1);
      chk("desc_stable", dd, prev_dd);
    end
    if (dv && !prev_dv) chk("desc_after_drain", 32'(part_q.size() + word_q.size()), 0);
    if (fwd) chk("conv_data", data, rx_byte_i);
    @(posedge clk);
    #1;
    if (wd_hs) begin
      w = word_q.pop_front();
      last_word = w;
      if (exp_word_q.size() == 0) chk("word_unexpected", 32'(exp_word_q.size()), 1);
      else chk("word", w, exp_word_q.pop_front());
    end
    if (fwd) begin
      fwd_cnt++;
      part_q.push_back(data);
      if (part_q.size() == 4) begin
        word_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
      end
    end
    if (flush_s) begin
      flush_cnt++;
      chk("flush_has_partial", 32'(part_q.size() != 0), 1);
      if (part_q.size() != 0) begin
        while (part_q.size() < 4) part_q.push_back(8'h00);
        word_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
      end
    end
    if (dv && dr) begin
      desc_cnt++;
      last_desc = dd;
      if (exp_desc_q.size() == 0) chk("desc_unexpected", 32'(exp_desc_q.size()), 1);
      else chk("desc", dd, exp_desc_q.pop_front());
    end
    if (bhs) byte_cnt++;
    last_byte_hs      = bhs;
    last_end_hs       = ehs;
    prev_dv           = dv;
    prev_dr           = dr;
    prev_dd           = dd;
    prev_flush        = flush_s;
    conv_word_valid_i = (word_q.size() != 0);
    conv_word_ready_i = pick(word_rdy_mode);
    desc_ready_i      = pick(desc_rdy_mode);
    conv_ready_i      = pick(conv_rdy_mode);
  endtask

  // Sends tx_q as one transfer and records what the converter and descriptor queue must see.
  task automatic send(input bit same);
    int n, stored, t;
    logic [31:0] w;
    n      = tx_q.size();
    stored = (n < MAXB) ? n : MAXB;
    for (int i = 0; i < stored; i += 4) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) if (i + k < stored) w[8*k +: 8] = tx_q[i+k];
      exp_word_q.push_back(w);
    end
    if (n > 0) exp_desc_q.push_back(32'(stored) | ((n > MAXB) ? 32'h8000_0000 : 32'h0));
    for (int i = 0; i < n; i++) begin
      rx_byte_i       = tx_q[i];
      rx_byte_valid_i = 1'b1;
      t = 0;
      do begin
        if (same && (i == n - 1)) begin
          rx_end_valid_i = 1'b1;
          conv_ready_i   = 1'b1;
        end
        cycle();
        t++;
        if (!last_byte_hs && t > 300) begin
          chk("byte_timeout", last_byte_hs, 1);
          finish_test();
        end
      end while (!last_byte_hs);
      rx_byte_valid_i = 1'b0;
      if (same && (i == n - 1)) begin
        chk("end_with_last_byte", last_end_hs, 1);
        rx_end_valid_i = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        cycle();
      end
    end
    if (!same || n == 0) begin
      rx_end_valid_i = 1'b1;
      t = 0;
      do begin
        cycle();
        t++;
        if (!last_end_hs && t > 300) begin
          chk("end_timeout", last_end_hs, 1);
          finish_test();
        end
      end while (!last_end_hs);
      rx_end_valid_i = 1'b0;
    end
    tx_q.delete();
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_desc_q.size() != 0 || exp_word_q.size() != 0) && t < 1000) begin
      cycle();
      t++;
    end
    chk("drain_done", 32'(exp_desc_q.size() + exp_word_q.size()), 0);
    repeat (2) cycle();
  endtask

  initial begin
    int f0, b0, w0, d0, t;
    rx_byte_valid_i = 1'b0; rx_byte_i = 8'h00; rx_end_valid_i = 1'b0;
    conv_ready_i = 1'b1; conv_word_valid_i = 1'b0; conv_word_ready_i = 1'b1; desc_ready_i = 1'b1;
    word_rdy_mode = 1; desc_rdy_mode = 1; conv_rdy_mode = 1;
    prev_dv = 1'b0; prev_dr = 1'b0; prev_dd = 32'd0; prev_flush = 1'b0;
    last_byte_hs = 1'b0; last_end_hs = 1'b0; last_desc = 32'd0; last_word = 32'd0;
    flush_cnt = 0; fwd_cnt = 0; byte_cnt = 0; desc_cnt = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_desc_valid", desc_valid_o, 0);
    chk("rst_desc_data", desc_data_o, 0);
    chk("rst_flush", conv_flush_o, 0);
    chk("rst_conv_valid", conv_valid_o, 0);
    chk("rst_end_rdy", rx_end_ready_o, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8 bytes, word aligned: no flush
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    f0 = flush_cnt; last_desc = 32'hdead_beef;
    send(1'b0);
    drain();
    chk("t1_flush_count", 32'(flush_cnt - f0), 0);
    chk("t1_desc", last_desc, 32'h0000_0008);
    chk("t1_last_word", last_word, 32'h0807_0605);

    // 5 bytes: partial word flushed
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(8'hA0 + i));
    f0 = flush_cnt; last_desc = 32'hdead_beef;
    send(1'b0);
    drain();
    chk("t2_flush_count", 32'(flush_cnt - f0), 1);
    chk("t2_desc", last_desc, 32'h0000_0005);
    chk("t2_last_word", last_word, 32'h0000_00A5);

    // 10 bytes against an 8-byte limit
    for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    b0 = byte_cnt; w0 = fwd_cnt; last_desc = 32'hdead_beef;
    send(1'b0);
    drain();
    chk("t3_bytes_accepted", 32'(byte_cnt - b0), 10);
    chk("t3_bytes_forwarded", 32'(fwd_cnt - w0), 8);
    chk("t3_desc", last_desc, 32'h8000_0008);

    // Word and descriptor backpressure
    word_rdy_mode = 0; conv_word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    send(1'b0);
    repeat (20) begin
      cycle();
      chk("t4_no_desc", desc_valid_o, 0);
      chk("t4_end_rdy_drain", rx_end_ready_o, 0);
    end
    desc_rdy_mode = 0; desc_ready_i = 1'b0;
    word_rdy_mode = 2; conv_word_ready_i = 1'b1;
    t = 0;
    while (!desc_valid_o && t < 100) begin
      cycle();
      t++;
    end
    chk("t4_desc_wait", desc_valid_o, 1);
    repeat (5) begin
      cycle();
      chk("t4_desc_hold", desc_valid_o, 1);
      chk("t4_desc_data", desc_data_o, 32'h0000_0008);
      chk("t4_byte_rdy", rx_byte_ready_o, 0);
      chk("t4_end_rdy", rx_end_ready_o, 0);
    end
    desc_rdy_mode = 1; word_rdy_mode = 1;
    drain();

    // Empty transfer, then end together with the third byte
    d0 = desc_cnt;
    send(1'b0);
    repeat (10) cycle();
    chk("t5_no_desc_count", 32'(desc_cnt - d0), 0);
    chk("t5_no_desc_valid", desc_valid_o, 0);
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    f0 = flush_cnt; last_desc = 32'hdead_beef;
    send(1'b1);
    drain();
    chk("t5_flush_count", 32'(flush_cnt - f0), 1);
    chk("t5_desc", last_desc, 32'h0000_0003);

    // Asynchronous reset while draining
    word_rdy_mode = 0; conv_word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    send(1'b0);
    repeat (3) cycle();
    chk("t6_pre_end_rdy", rx_end_ready_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_desc_valid", desc_valid_o, 0);
    chk("t6_rst_flush", conv_flush_o, 0);
    chk("t6_rst_desc_data", desc_data_o, 0);
    chk("t6_rst_end_rdy", rx_end_ready_o, 1);
    chk("t6_rst_byte_rdy", rx_byte_ready_o, conv_ready_i);
    part_q.delete(); word_q.delete(); exp_word_q.delete(); exp_desc_q.delete();
    prev_dv = 1'b0; prev_dr = 1'b0; prev_flush = 1'b0;
    conv_word_valid_i = 1'b0; word_rdy_mode = 1;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    last_desc = 32'hdead_beef;
    send(1'b0);
    drain();
    chk("t6_desc_after_reset", last_desc, 32'h0000_0004);

    // Randomized transfers with random backpressure everywhere
    repeat (40) begin
      int n;
      bit same;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      same = (n > 0) && ($urandom_range(0, 1) == 1);
      send(same);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) cycle();
    end
    drain();

    finish_test();
  end
endmodule
